// File: rtl/ldtu_encoder.sv
// LiTe-DTU encoder: packs baseline (6-bit) and signal (13-bit) samples into 32-bit words.
// Optional word counter is enabled by defining LDTU_ENC_WCNT_EN.
module ldtu_encoder (
   input  logic        CLK,
   input  logic        reset_,
   input  logic [12:0] DATA_in,
   input  logic        baseline_flag,
   input  logic        enable,
   input  logic        flush,
   output logic [31:0] DATA_32,
   output logic        data_valid,
   output logic [15:0] word_count
);

   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      BASE1 = 3'd1,
      BASE2 = 3'd2,
      BASE3 = 3'd3,
      BASE4 = 3'd4,
      SIG   = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [23:0] base_buf, base_buf_nxt;
   logic [12:0] sig_buf, sig_buf_nxt;
   logic        emit;
   logic [31:0] word;
   logic [2:0]  base_cnt;
   logic [4:0]  shift_amt;
   logic [5:0]  sample6;
   logic [31:0] partial_base;
   logic [31:0] partial_sig;

   // Baseline samples pack upwards from bit 0; bits above the fill level stay 0.
   always_comb begin
      state_nxt    = state;
      base_buf_nxt = base_buf;
      sig_buf_nxt  = sig_buf;
      emit         = 1'b0;
      word         = 32'h0;
      sample6      = DATA_in[5:0];

      case (state)
         BASE1:   base_cnt = 3'd1;
         BASE2:   base_cnt = 3'd2;
         BASE3:   base_cnt = 3'd3;
         BASE4:   base_cnt = 3'd4;
         default: base_cnt = 3'd0;
      endcase

      shift_amt    = 5'd6 * {2'b00, base_cnt};
      partial_base = {5'b11010, base_cnt, base_buf};
      partial_sig  = {6'b001011, 13'h0, sig_buf};

      if (flush) begin
         state_nxt    = EMPTY;
         base_buf_nxt = 24'h0;
         sig_buf_nxt  = 13'h0;
         if (state == SIG) begin
            emit = 1'b1;
            word = partial_sig;
         end else if (base_cnt != 3'd0) begin
            emit = 1'b1;
            word = partial_base;
         end
      end else if (enable) begin
         case (state)
            EMPTY: begin
               if (baseline_flag) begin
                  state_nxt    = BASE1;
                  base_buf_nxt = {18'h0, sample6};
               end else begin
                  state_nxt   = SIG;
                  sig_buf_nxt = DATA_in;
               end
            end
            BASE1, BASE2, BASE3, BASE4: begin
               if (baseline_flag) begin
                  if (state == BASE4) begin
                     emit         = 1'b1;
                     word         = {2'b01, sample6, base_buf};
                     state_nxt    = EMPTY;
                     base_buf_nxt = 24'h0;
                  end else begin
                     base_buf_nxt = base_buf | ({18'h0, sample6} << shift_amt);
                     case (state)
                        BASE1:   state_nxt = BASE2;
                        BASE2:   state_nxt = BASE3;
                        default: state_nxt = BASE4;
                     endcase
                  end
               end else begin
                  emit         = 1'b1;
                  word         = partial_base;
                  state_nxt    = SIG;
                  base_buf_nxt = 24'h0;
                  sig_buf_nxt  = DATA_in;
               end
            end
            SIG: begin
               emit = 1'b1;
               if (baseline_flag) begin
                  word         = partial_sig;
                  state_nxt    = BASE1;
                  base_buf_nxt = {18'h0, sample6};
                  sig_buf_nxt  = 13'h0;
               end else begin
                  word        = {6'b001010, DATA_in, sig_buf};
                  state_nxt   = EMPTY;
                  sig_buf_nxt = 13'h0;
               end
            end
            default: begin
               state_nxt    = EMPTY;
               base_buf_nxt = 24'h0;
               sig_buf_nxt  = 13'h0;
            end
         endcase
      end
   end

   // DATA_32 only changes on an emission, so it holds the last word between strobes.
   always_ff @(posedge CLK or negedge reset_) begin
      if (!reset_) begin
         state      <= EMPTY;
         base_buf   <= 24'h0;
         sig_buf    <= 13'h0;
         DATA_32    <= 32'h0;
         data_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         base_buf   <= base_buf_nxt;
         sig_buf    <= sig_buf_nxt;
         data_valid <= emit;
         if (emit) begin
            DATA_32 <= word;
         end
      end
   end

`ifdef LDTU_ENC_WCNT_EN
   logic [15:0] wcnt;

   always_ff @(posedge CLK or negedge reset_) begin
      if (!reset_) begin
         wcnt <= 16'h0;
      end else if (emit) begin
         wcnt <= wcnt + 16'd1;
      end
   end

   assign word_count = wcnt;
`else
   assign word_count = 16'h0;
`endif

endmodule

// File: tb/tb_ldtu_encoder.sv
// Self-checking bench for ldtu_encoder: directed word-format cases plus random
// stimulus compared against a queue-based packing model.
module tb_ldtu_encoder;

   logic        CLK;
   logic        reset_;
   logic [12:0] DATA_in;
   logic        baseline_flag;
   logic        enable;
   logic        flush;
   logic [31:0] DATA_32;
   logic        data_valid;
   logic [15:0] word_count;

   int compared   = 0;
   int mismatched = 0;

   logic [12:0] pend[$];
   bit          pend_base;
   logic [31:0] exp_word;
   logic        exp_valid;
   logic [15:0] exp_wcnt;

   ldtu_encoder dut (
      .CLK          (CLK),
      .reset_       (reset_),
      .DATA_in      (DATA_in),
      .baseline_flag(baseline_flag),
      .enable       (enable),
      .flush        (flush),
      .DATA_32      (DATA_32),
      .data_valid   (data_valid),
      .word_count   (word_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Baseline samples are weighted by powers of 64, oldest lowest.
   function automatic logic [31:0] baseSum();
      logic [31:0] acc    = 32'h0;
      logic [31:0] weight = 32'h1;
      foreach (pend[i]) begin
         acc    = acc + {26'h0, pend[i][5:0]} * weight;
         weight = weight * 32'd64;
      end
      return acc;
   endfunction

   function automatic logic [31:0] partialWord();
      if (pend_base)
         return 32'hD000_0000 + pend.size() * 32'h0100_0000 + baseSum();
      else
         return 32'h2C00_0000 + {19'h0, pend[0]};
   endfunction

   task automatic modelReset();
      pend.delete();
      pend_base = 1'b0;
      exp_word  = 32'h0;
      exp_valid = 1'b0;
      exp_wcnt  = 16'h0;
   endtask

   task automatic modelStep(input logic en, input logic fl, input logic bf,
                            input logic [12:0] d);
      logic [12:0] s;
      exp_valid = 1'b0;
      if (fl) begin
         if (pend.size() > 0) begin
            exp_word  = partialWord();
            exp_valid = 1'b1;
         end
         pend.delete();
      end else if (en) begin
         s = bf ? {7'h0, d[5:0]} : d;
         if (pend.size() == 0) begin
            pend.push_back(s);
            pend_base = bf;
         end else if (pend_base == bf) begin
            pend.push_back(s);
            if (bf && pend.size() == 5) begin
               exp_word  = 32'h4000_0000 + baseSum();
               exp_valid = 1'b1;
               pend.delete();
            end else if (!bf && pend.size() == 2) begin
               exp_word  = 32'h2800_0000 + {19'h0, pend[1]} * 32'd8192 + {19'h0, pend[0]};
               exp_valid = 1'b1;
               pend.delete();
            end
         end else begin
            exp_word  = partialWord();
            exp_valid = 1'b1;
            pend.delete();
            pend.push_back(s);
            pend_base = bf;
         end
      end
`ifdef LDTU_ENC_WCNT_EN
      if (exp_valid) exp_wcnt = exp_wcnt + 16'd1;
`endif
   endtask

   task automatic applyStimulus(input logic en, input logic fl, input logic bf,
                                input logic [12:0] d);
      enable        = en;
      flush         = fl;
      baseline_flag = bf;
      DATA_in       = d;
      modelStep(en, fl, bf, d);
      @(posedge CLK);
      #1;
      checkOutput("data_valid", {31'h0, data_valid}, {31'h0, exp_valid});
      checkOutput("DATA_32", DATA_32, exp_word);
      checkOutput("word_count", {16'h0, word_count}, {16'h0, exp_wcnt});
   endtask

   initial begin
      reset_        = 1'b0;
      enable        = 1'b0;
      flush         = 1'b0;
      baseline_flag = 1'b0;
      DATA_in       = 13'h0;
      modelReset();
      #12;
      checkOutput("rst_data32", DATA_32, 32'h0);
      checkOutput("rst_valid", {31'h0, data_valid}, 32'h0);
      checkOutput("rst_wcnt", {16'h0, word_count}, 32'h0);
      #2 reset_ = 1'b1;
      @(posedge CLK);
      #1;

      // Five baselines make one full word on the fifth edge
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 13'(i));
      checkOutput("req27_word", DATA_32, 32'h4510_3081);
      checkOutput("req27_valid", {31'h0, data_valid}, 32'h1);

      applyStimulus(1'b1, 1'b0, 1'b0, 13'h0123);
      applyStimulus(1'b1, 1'b0, 1'b0, 13'h1ABC);
      checkOutput("req28_word", DATA_32, 32'h2B57_8123);

      applyStimulus(1'b1, 1'b0, 1'b1, 13'd7);
      applyStimulus(1'b1, 1'b0, 1'b1, 13'd9);
      applyStimulus(1'b1, 1'b0, 1'b0, 13'h1000);
      checkOutput("req29_word", DATA_32, 32'hD200_0247);
      applyStimulus(1'b0, 1'b1, 1'b0, 13'h0);
      checkOutput("req29_sig_flush", DATA_32, 32'h2C00_1000);

      applyStimulus(1'b1, 1'b0, 1'b0, 13'h0FFF);
      applyStimulus(1'b1, 1'b0, 1'b1, 13'd3);
      checkOutput("req30_word", DATA_32, 32'h2C00_0FFF);
      applyStimulus(1'b1, 1'b1, 1'b0, 13'h1555);
      checkOutput("req30_flush", DATA_32, 32'hD100_0003);
      applyStimulus(1'b0, 1'b1, 1'b0, 13'h0);
      checkOutput("flush_empty", {31'h0, data_valid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 13'h3F);
      checkOutput("hold_idle", {31'h0, data_valid}, 32'h0);

      // Asynchronous reset in BASE(3), away from any clock edge
      for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 13'(i + 40));
      #2 reset_ = 1'b0;
      #1;
      modelReset();
      checkOutput("req31_data32", DATA_32, 32'h0);
      checkOutput("req31_valid", {31'h0, data_valid}, 32'h0);
      checkOutput("req31_wcnt", {16'h0, word_count}, 32'h0);
      #2 reset_ = 1'b1;
      for (int i = 10; i <= 14; i++) applyStimulus(1'b1, 1'b0, 1'b1, 13'(i));
      checkOutput("req31_word", DATA_32, 32'h4E34_C2CA);

      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom % 4) != 0, ($urandom % 8) == 0,
                       1'($urandom % 2), 13'($urandom));
      end

      // Alternating signal/baseline emits one partial word per cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 13'h0);
      #2 reset_ = 1'b0;
      #1 modelReset();
      #2 reset_ = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 13'h0AA);
`ifdef LDTU_ENC_WCNT_EN
      for (int i = 0; i < 65537; i++)
         applyStimulus(1'b1, 1'b0, 1'(i % 2 == 0), 13'(i));
      checkOutput("req32_wcnt", {16'h0, word_count}, 32'h1);
`else
      for (int i = 0; i < 1000; i++)
         applyStimulus(1'b1, 1'b0, 1'(i % 2 == 0), 13'(i));
      checkOutput("req32_wcnt", {16'h0, word_count}, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
